// File: rtl/instr_fetch.sv
// Instruction fetch stage: word-addressed PC, branch/jump redirect, IF/ID register.
// Optional bounds check against DEPTH is compiled in with `define FETCH_BOUNDS_EN.
module instr_fetch #(
  parameter int N     = 32,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic         branch_taken_i,
  input  logic [15:0]  branch_offset_i,
  input  logic         jump_i,
  input  logic [25:0]  jump_index_i,
  output logic [N-1:0] rom_addr_o,
  input  logic [N-1:0] rom_instr_i,
  output logic [N-1:0] ifid_instr_o,
  output logic [N-1:0] ifid_pc_plus1_o,
  output logic         ifid_valid_o,
  output logic         fault_o
);

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] instr_q, instr_d;
  logic [N-1:0] pc1_q, pc1_d;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;

  logic [N-1:0] pc_inc;
  logic [N-1:0] br_tgt;
  logic [N-1:0] jmp_tgt;
  logic         oob;

  assign pc_inc  = pc_q + N'(1);
  assign br_tgt  = pc1_q + N'($signed(branch_offset_i));
  assign jmp_tgt = N'({pc1_q[N-1:N-4], jump_index_i, 2'b00});

`ifdef FETCH_BOUNDS_EN
  assign oob = (pc_q >= N'(DEPTH));
`else
  assign oob = 1'b0;
`endif

  // Next-state, next-PC and IF/ID load selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    fault_d = fault_q;
    unique case (state_q)
      START: begin
        state_d = RUN;
        pc_d    = '0;
        instr_d = '0;
        valid_d = 1'b0;
      end
      RUN: begin
        if (oob) begin
          state_d = HALT;
          fault_d = 1'b1;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (branch_taken_i) begin
          pc_d    = br_tgt;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (jump_i) begin
          pc_d    = jmp_tgt;
          instr_d = '0;
          valid_d = 1'b0;
        end else begin
          if (!stall_i) begin
            pc_d = pc_inc;
          end
          if (flush_i) begin
            instr_d = '0;
            valid_d = 1'b0;
          end else if (!stall_i) begin
            instr_d = rom_instr_i;
            pc1_d   = pc_inc;
            valid_d = 1'b1;
          end
        end
      end
      HALT: begin
        instr_d = '0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = START;
      end
    endcase
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= START;
      pc_q    <= '0;
      instr_q <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign rom_addr_o      = pc_q;
  assign ifid_instr_o    = instr_q;
  assign ifid_pc_plus1_o = pc1_q;
  assign ifid_valid_o    = valid_q;
  assign fault_o         = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus random traffic
// checked against a behavioural fetch model.
module tb_instr_fetch;
  localparam int N     = 32;
  localparam int DEPTH = 32;
`ifdef FETCH_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_i, flush_i, branch_taken_i, jump_i;
  logic [15:0]   branch_offset_i;
  logic [25:0]   jump_index_i;
  logic [N-1:0]  rom_addr_o, rom_instr_i;
  logic [N-1:0]  ifid_instr_o, ifid_pc_plus1_o;
  logic          ifid_valid_o, fault_o;

  int tests = 0;
  int fails = 0;

  // model state
  logic [31:0] m_pc, m_instr, m_pc1;
  logic        m_valid, m_fault;
  int          m_mode; // 0 = START, 1 = RUN, 2 = HALT

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign rom_instr_i = rom(rom_addr_o);

  instr_fetch #(.N(N), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_taken_i  (branch_taken_i),
    .branch_offset_i (branch_offset_i),
    .jump_i          (jump_i),
    .jump_index_i    (jump_index_i),
    .rom_addr_o      (rom_addr_o),
    .rom_instr_i     (rom_instr_i),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_pc_plus1_o (ifid_pc_plus1_o),
    .ifid_valid_o    (ifid_valid_o),
    .fault_o         (fault_o)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_pc"}, rom_addr_o, m_pc);
    check({tag, "_instr"}, ifid_instr_o, m_instr);
    check({tag, "_pc1"}, ifid_pc_plus1_o, m_pc1);
    check({tag, "_valid"}, {31'b0, ifid_valid_o}, {31'b0, m_valid});
    check({tag, "_fault"}, {31'b0, fault_o}, {31'b0, m_fault});
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pc1 = 0;
    m_valid = 0; m_fault = 0; m_mode = 0;
  endtask

  task automatic bubble();
    m_instr = 0;
    m_valid = 0;
  endtask

  // Apply the fetch rules for one rising edge, using current inputs.
  task automatic model_edge();
    logic [31:0] off;
    if (rst) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_mode = 1;
      bubble();
    end else if (m_mode == 2) begin
      bubble();
    end else if (BOUNDS && m_pc >= DEPTH) begin
      m_mode = 2;
      m_fault = 1;
      bubble();
    end else if (branch_taken_i) begin
      off = {{16{branch_offset_i[15]}}, branch_offset_i};
      m_pc = m_pc1 + off;
      bubble();
    end else if (jump_i) begin
      m_pc = (m_pc1 & 32'hF000_0000) | ({6'b0, jump_index_i} << 2);
      bubble();
    end else begin
      if (flush_i) begin
        bubble();
      end else if (!stall_i) begin
        m_instr = rom(m_pc);
        m_pc1 = m_pc + 1;
        m_valid = 1;
      end
      if (!stall_i) m_pc = m_pc + 1;
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic br,
                       input logic [15:0] off, input logic jp,
                       input logic [25:0] idx);
    stall_i = st; flush_i = fl; branch_taken_i = br;
    branch_offset_i = off; jump_i = jp; jump_index_i = idx;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_drive();
    logic [15:0] off;
    off = 16'($signed($urandom_range(13, 0)) - 10);
    drive(($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0),
          ($urandom_range(9, 0) == 0), off,
          ($urandom_range(9, 0) == 0), 26'($urandom_range(5, 0)));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 16'h0, 0, 26'h0);
    model_reset();
    #1;
    check_all("rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;

    // START cycle, then sequential fetch
    step("start");
    check("start_valid", {31'b0, ifid_valid_o}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step("seq");
      check("seq_pc1", ifid_pc_plus1_o, k);
      check("seq_valid", {31'b0, ifid_valid_o}, 32'd1);
    end
    step("seq5");
    check("pre_branch_pc1", ifid_pc_plus1_o, 32'd5);

    // backward branch
    drive(0, 0, 1, 16'hFFFD, 0, 26'h0);
    step("branch");
    check("branch_pc", rom_addr_o, 32'd2);
    check("branch_bubble", {31'b0, ifid_valid_o}, 32'd0);
    drive(0, 0, 0, 16'h0, 0, 26'h0);
    step("after_branch");
    check("after_branch_pc1", ifid_pc_plus1_o, 32'd3);

    // branch beats jump, then jump alone
    drive(0, 0, 1, 16'h0, 1, 26'd4);
    step("br_vs_jmp");
    check("br_wins_pc", rom_addr_o, 32'd3);
    drive(0, 0, 0, 16'h0, 1, 26'd4);
    step("jump");
    check("jump_pc", rom_addr_o, 32'd16);

    // reach PC=6 with a valid IF/ID entry, then stall
    drive(0, 0, 1, 16'd2, 0, 26'h0);
    step("to5");
    drive(0, 0, 0, 16'h0, 0, 26'h0);
    step("to6");
    check("pc6", rom_addr_o, 32'd6);
    drive(1, 0, 0, 16'h0, 0, 26'h0);
    for (int k = 0; k < 3; k++) begin
      step("stall");
      check("stall_pc", rom_addr_o, 32'd6);
      check("stall_pc1", ifid_pc_plus1_o, 32'd6);
      check("stall_valid", {31'b0, ifid_valid_o}, 32'd1);
    end
    drive(1, 1, 0, 16'h0, 0, 26'h0);
    step("stall_flush");
    check("sf_valid", {31'b0, ifid_valid_o}, 32'd0);
    check("sf_pc", rom_addr_o, 32'd6);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      rand_drive();
      step("rand");
    end

    // asynchronous reset in the middle of a stall
    drive(1, 0, 0, 16'h0, 0, 26'h0);
    step("pre_rst_stall");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst_stall");
    step("rst_held");
    rst = 1'b0;
    drive(0, 0, 0, 16'h0, 0, 26'h0);
    step("restart_start");
    step("restart_fetch");
    check("restart_instr", ifid_instr_o, rom(32'd0));
    check("restart_pc1", ifid_pc_plus1_o, 32'd1);

    // jump to the first out-of-range word
    drive(0, 0, 0, 16'h0, 1, 26'd8);
    step("jump32");
    check("jump32_pc", rom_addr_o, 32'd32);
    drive(0, 0, 0, 16'h0, 0, 26'h0);
    step("oob1");
    step("oob2");
`ifdef FETCH_BOUNDS_EN
    check("oob_fault", {31'b0, fault_o}, 32'd1);
    check("oob_pc_frozen", rom_addr_o, 32'd32);
`else
    check("oob_fault", {31'b0, fault_o}, 32'd0);
    check("oob_pc1", ifid_pc_plus1_o, 32'd34);
`endif
    for (int k = 0; k < 10; k++) begin
      rand_drive();
      step("post_oob");
    end

    // asynchronous reset from HALT (or free running without bounds)
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst_halt");
    check("halt_rst_fault", {31'b0, fault_o}, 32'd0);
    step("rst_held2");
    rst = 1'b0;
    drive(0, 0, 0, 16'h0, 0, 26'h0);
    step("restart2_start");
    step("restart2_fetch");
    check("restart2_pc1", ifid_pc_plus1_o, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
